fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the instruction memory. It holds the program counter and drives the byte address to the combinational instruction memory. It captures the returned 32-bit word into the IF/ID pipeline register, together with PC and PC+4. It supports decode-stage stalls and execute-stage redirects (taken branch / jump), which flush the captured instruction.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/fetch_stage_pc_reg.sv | 28 ++
 rtl/fetch_stage.sv | 64 ++++++
 tb/tb_fetch_stage.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the fetch pipeline.
package cpu_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned RESET_PC_DEFAULT = 0;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter with reset / redirect / stall / +4 next-PC selection.
module pc_reg
    import cpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    output logic [ADDRESS_WIDTH-1:0] pc_q_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o
);
    logic [ADDRESS_WIDTH-1:0] r_pc;
    assign pc_q_o     = r_pc;
    assign pc_plus4_o = r_pc + ADDRESS_WIDTH'(INSTR_BYTES);
    // Redirect targets are word-aligned by dropping the low two bits.
    always_ff @(posedge clk) begin
        if (rst)
            r_pc <= RESET_PC;
        else if (redirect_i)
            r_pc <= {redirect_target_i[ADDRESS_WIDTH-1:2], 2'b00};
        else if (!stall_i)
            r_pc <= pc_plus4_o;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: drives the instruction-memory address and captures the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target_i,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o,
    output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
    output logic                     valid_o
);
    logic [ADDRESS_WIDTH-1:0] w_pc_q;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0]    r_instr;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] r_pc_plus4;
    logic                     r_valid;

    pc_reg #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .RESET_PC     (RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_target_i(redirect_target_i),
        .pc_q_o           (w_pc_q),
        .pc_plus4_o       (w_pc_plus4)
    );

    assign addr_o     = w_pc_q;
    assign instr_o    = r_instr;
    assign pc_o       = r_pc;
    assign pc_plus4_o = r_pc_plus4;
    assign valid_o    = r_valid;

    // A redirect flushes the word fetched down the wrong path but keeps the old PC fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= DATA_WIDTH'(NOP_INSTR);
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (redirect_i) begin
            r_instr <= DATA_WIDTH'(NOP_INSTR);
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            r_instr    <= instr_i;
            r_pc       <= w_pc_q;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random fetch sequences against a behavioural model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [7:0]  redirect_target_i = '0;
    logic [7:0]  addr_o;
    logic [31:0] instr_i;
    logic [31:0] instr_o;
    logic [7:0]  pc_o;
    logic [7:0]  pc_plus4_o;
    logic        valid_o;

    logic [31:0] mem [64];
    int n_cmp = 0;
    int n_err = 0;
    int m_pc, m_pco, m_pc4, m_valid;
    logic [31:0] m_instr;

    always #5 clk = ~clk;
    assign instr_i = mem[addr_o[7:2]];

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_target_i(redirect_target_i),
        .addr_o           (addr_o),
        .instr_i          (instr_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o),
        .valid_o          (valid_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit d, input int t);
        rst = r;
        stall_i = s;
        redirect_i = d;
        redirect_target_i = 8'(t);
        if (r) begin
            m_pc = 0; m_instr = 32'h13; m_pco = 0; m_pc4 = 0; m_valid = 0;
        end else if (d) begin
            m_pc = (t / 4) * 4; m_instr = 32'h13; m_valid = 0;
        end else if (!s) begin
            m_instr = mem[m_pc / 4]; m_pco = m_pc; m_pc4 = (m_pc + 4) % 256; m_valid = 1;
            m_pc = (m_pc + 4) % 256;
        end
        @(posedge clk);
        #1;
        chk("addr", 32'(addr_o), 32'(m_pc));
        chk("instr", instr_o, m_instr);
        chk("pc", 32'(pc_o), 32'(m_pco));
        chk("pc4", 32'(pc_plus4_o), 32'(m_pc4));
        chk("valid", 32'(valid_o), 32'(m_valid));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_addr", 32'(addr_o), 32'h0);
        chk("rst_instr", instr_o, 32'h13);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        chk("pre_stall_addr", 32'(addr_o), 32'h08);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        chk("stall_hold_pc", 32'(pc_o), 32'h04);
        chk("stall_hold_instr", instr_o, mem[1]);
        step(0, 0, 0, 0);
        chk("post_stall_instr", instr_o, mem[2]);
        step(0, 0, 0, 0);
        chk("pre_redir_addr", 32'(addr_o), 32'h10);
        step(0, 0, 1, 'h40);
        chk("redir_bubble", 32'(valid_o), 32'h0);
        step(0, 0, 0, 0);
        chk("redir_pc", 32'(pc_o), 32'h40);
        chk("redir_instr", instr_o, mem[16]);
        step(0, 1, 1, 'h23);
        chk("redir_stall_addr", 32'(addr_o), 32'h20);
        step(0, 0, 1, 'hFC);
        step(0, 0, 0, 0);
        chk("wrap_addr", 32'(addr_o), 32'h0);
        chk("wrap_pc", 32'(pc_o), 32'hFC);
        chk("wrap_pc4", 32'(pc_plus4_o), 32'h0);
        step(0, 0, 1, 'h30);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("mid_stall_rst_valid", 32'(valid_o), 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("resume_pc", 32'(pc_o), 32'h04);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 255)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
